// File: rtl/pakout_tx_pkg.sv
// Shared sizing helpers, FSM encoding and default widths for pakout_tx.
// Build macro PAKOUT_TX_REDUN_CHECK_EN enables redundancy checking in the top.
`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 8
`endif
`ifndef NS_PACKIN_FSZ
`define NS_PACKIN_FSZ 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 6
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 32
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

package pakout_tx_pkg;

    function automatic int unsigned msg_sz(input int unsigned asz, input int unsigned dsz,
                                           input int unsigned rsz);
        return 2 * asz + dsz + rsz;
    endfunction

    function automatic int unsigned tot_pks(input int unsigned msz, input int unsigned psz);
        return (msz / psz) + 1;
    endfunction

    function automatic int unsigned clog2_fl(input int unsigned n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    // Index/pointer width; a zero-width counter still needs one bit of storage.
    function automatic int unsigned idx_w(input int unsigned n);
        return (clog2_fl(n) == 0) ? 1 : clog2_fl(n);
    endfunction

    localparam int unsigned MSG_SZ  = msg_sz(`NS_ADDRESS_SIZE, `NS_DATA_SIZE, `NS_REDUN_SIZE);
    localparam int unsigned TOT_PKS = tot_pks(MSG_SZ, `NS_PACKET_SIZE);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend,
        StWaitLo
    } state_e;

endpackage

// File: rtl/pakout_tx_calc_redun.sv
// Redundancy generator: XOR-fold of {src,dst,dat} into RSZ-bit chunks, zero padded at the top.
module calc_redun #(
    parameter int unsigned ASZ = 6,
    parameter int unsigned DSZ = 32,
    parameter int unsigned RSZ = 4
) (
    input  logic [ASZ-1:0] src_i,
    input  logic [ASZ-1:0] dst_i,
    input  logic [DSZ-1:0] dat_i,
    output logic [RSZ-1:0] red_o
);
    localparam int unsigned InW = 2 * ASZ + DSZ;
    localparam int unsigned NCh = (InW + RSZ - 1) / RSZ;

    logic [NCh*RSZ-1:0] pad;

    always_comb begin
        pad   = (NCh*RSZ)'({src_i, dst_i, dat_i});
        red_o = '0;
        for (int j = 0; j < NCh; j++) begin
            red_o = red_o ^ RSZ'(pad >> (j * RSZ));
        end
    end
endmodule

// File: rtl/pakout_tx.sv
// Message-to-packet serialiser: 4-phase handshakes on both sides, message FIFO in between.
// Define PAKOUT_TX_REDUN_CHECK_EN to drop messages with a bad redundancy field and flag err_red.
module pakout_tx
    import pakout_tx_pkg::*;
#(
    parameter int unsigned PSZ = `NS_PACKET_SIZE,
    parameter int unsigned FSZ = `NS_PACKIN_FSZ,
    parameter int unsigned ASZ = `NS_ADDRESS_SIZE,
    parameter int unsigned DSZ = `NS_DATA_SIZE,
    parameter int unsigned RSZ = `NS_REDUN_SIZE
) (
    input  logic           src_clk,
    input  logic           reset,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i0_req,
    output logic           i0_ack,
    output logic [PSZ-1:0] o0_pak,
    output logic           o0_req,
    input  logic           o0_ack,
    output logic           err_red,
    output logic [7:0]     sent_cnt
);
    localparam int unsigned MsgW   = msg_sz(ASZ, DSZ, RSZ);
    localparam int unsigned TotPks = tot_pks(MsgW, PSZ);
    localparam int unsigned ShW    = TotPks * PSZ;
    localparam int unsigned IdxW   = idx_w(TotPks);
    localparam int unsigned AW     = idx_w(FSZ);
    localparam int unsigned PtrW   = AW + 1;

    logic [1:0]      req_sync_q, ack_sync_q;
    logic            i0_req_s, o0_ack_s;
    logic            i0_ack_q, i0_ack_d;
    logic            accept, red_ok, wr_en, pop;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            full, empty;
    logic [MsgW-1:0] mem_q [FSZ];
    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [ShW-1:0]  sh_q, sh_d;
    logic            o0_req_q;
    logic [7:0]      cnt_q, cnt_d;

    assign i0_req_s = req_sync_q[1];
    assign o0_ack_s = ack_sync_q[1];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Accept only from idle ack; a full FIFO holds the requester off rather than dropping.
    assign accept   = i0_req_s && !i0_ack_q && !full;
    assign i0_ack_d = i0_ack_q ? i0_req_s : accept;
    assign wr_en    = accept && red_ok;

`ifdef PAKOUT_TX_REDUN_CHECK_EN
    logic [RSZ-1:0] red_calc;
    logic           err_red_q;

    calc_redun #(
        .ASZ(ASZ),
        .DSZ(DSZ),
        .RSZ(RSZ)
    ) u_calc_redun (
        .src_i(i0_src),
        .dst_i(i0_dst),
        .dat_i(i0_dat),
        .red_o(red_calc)
    );

    assign red_ok = (red_calc == i0_red);

    always_ff @(posedge src_clk or posedge reset) begin
        if (reset) begin
            err_red_q <= 1'b0;
        end else if (accept && !red_ok) begin
            err_red_q <= 1'b1;
        end
    end

    assign err_red = err_red_q;
`else
    assign red_ok  = 1'b1;
    assign err_red = 1'b0;
`endif

    assign wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    always_ff @(posedge src_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {i0_src, i0_dst, i0_dat, i0_red};
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) state_d = StLoad;
            end
            StLoad: begin
                sh_d    = ShW'(mem_q[rd_ptr_q[AW-1:0]]);
                idx_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                if (o0_ack_s) state_d = StWaitLo;
            end
            StWaitLo: begin
                if (!o0_ack_s) begin
                    if (idx_q == IdxW'(TotPks - 1)) begin
                        pop     = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        sh_d    = sh_q << PSZ;
                        state_d = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge src_clk or posedge reset) begin
        if (reset) begin
            req_sync_q <= '0;
            ack_sync_q <= '0;
            i0_ack_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= StIdle;
            idx_q      <= '0;
            sh_q       <= '0;
            o0_req_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            req_sync_q <= {req_sync_q[0], i0_req};
            ack_sync_q <= {ack_sync_q[0], o0_ack};
            i0_ack_q   <= i0_ack_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            sh_q       <= sh_d;
            o0_req_q   <= (state_d == StSend);
            cnt_q      <= cnt_d;
        end
    end

    // Current packet is always the top slice; the register only moves between requests.
    assign o0_pak   = sh_q[ShW-1 -: PSZ];
    assign o0_req   = o0_req_q;
    assign i0_ack   = i0_ack_q;
    assign sent_cnt = cnt_q;
endmodule

// File: tb/tb_pakout_tx.sv
// Directed bench for pakout_tx with PSZ=8, FSZ=4, ASZ=6, DSZ=32, RSZ=4 (7 packets per message).
module tb_pakout_tx;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  i0_src, i0_dst;
    logic [31:0] i0_dat;
    logic [3:0]  i0_red;
    logic        i0_req, i0_ack;
    logic [7:0]  o0_pak;
    logic        o0_req, o0_ack;
    logic        err_red;
    logic [7:0]  sent_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pakout_tx #(
        .PSZ(8),
        .FSZ(4),
        .ASZ(6),
        .DSZ(32),
        .RSZ(4)
    ) dut (
        .src_clk (clk),
        .reset   (rst),
        .i0_src  (i0_src),
        .i0_dst  (i0_dst),
        .i0_dat  (i0_dat),
        .i0_red  (i0_red),
        .i0_req  (i0_req),
        .i0_ack  (i0_ack),
        .o0_pak  (o0_pak),
        .o0_req  (o0_req),
        .o0_ack  (o0_ack),
        .err_red (err_red),
        .sent_cnt(sent_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] redun(input logic [5:0] s, input logic [5:0] d,
                                         input logic [31:0] dt);
        logic [43:0] v;
        v = {s, d, dt};
        return v[3:0] ^ v[7:4] ^ v[11:8] ^ v[15:12] ^ v[19:16] ^ v[23:20] ^ v[27:24]
             ^ v[31:28] ^ v[35:32] ^ v[39:36] ^ v[43:40];
    endfunction

    function automatic logic [47:0] gen(input int i);
        logic [7:0]  b;
        logic [5:0]  s, d;
        logic [31:0] dt;
        b  = i[7:0];
        s  = b[5:0];
        d  = ~b[5:0];
        dt = {b, ~b, b ^ 8'h5a, 8'hc3};
        return {s, d, dt, redun(s, d, dt)};
    endfunction

    function automatic logic [7:0] pkt(input logic [47:0] m, input int k);
        logic [55:0] e;
        e = {8'h00, m};
        return e[55-8*k -: 8];
    endfunction

    task automatic wait_req(input logic lvl, input string tag);
        int n;
        n = 0;
        while (o0_req !== lvl && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (o0_req !== lvl) check(tag, o0_req, lvl);
    endtask

    task automatic push(input logic [47:0] m);
        int n;
        @(negedge clk);
        {i0_src, i0_dst, i0_dat, i0_red} = m;
        i0_req = 1'b1;
        n = 0;
        while (i0_ack !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("push_ack", i0_ack, 1'b1);
        i0_req = 1'b0;
        n = 0;
        while (i0_ack !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("push_ack_clr", i0_ack, 1'b0);
    endtask

    task automatic recv_pkt(input logic [7:0] exp, input string tag);
        wait_req(1'b1, "req_rise_timeout");
        check(tag, o0_pak, exp);
        o0_ack = 1'b1;
        wait_req(1'b0, "req_fall_timeout");
        o0_ack = 1'b0;
    endtask

    task automatic recv_msg(input logic [47:0] m);
        for (int k = 0; k < 7; k++) recv_pkt(pkt(m, k), "pkt");
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  exp1 [7];
        logic [47:0] m1, ma, mb, mc, mbad;
        logic [47:0] mq [5];
        logic [7:0]  p;
        logic        ok;
        int          n;

        exp1 = '{8'h00, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h58};
        rst = 1'b1;
        i0_req = 1'b0;
        o0_ack = 1'b0;
        {i0_src, i0_dst, i0_dat, i0_red} = '0;
        repeat (3) @(negedge clk);
        check("rst_o0_req", o0_req, 1'b0);
        check("rst_i0_ack", i0_ack, 1'b0);
        check("rst_o0_pak", o0_pak, 8'h00);
        check("rst_err_red", err_red, 1'b0);
        check("rst_sent_cnt", sent_cnt, 8'd0);
        rst = 1'b0;

        // Single message, hand-computed bytes; long stall on packet 2.
        m1 = {6'd3, 6'd1, 32'h0000_0005, 4'h8};
        push(m1);
        for (int k = 0; k < 7; k++) begin
            if (k == 2) begin
                wait_req(1'b1, "req_rise_timeout");
                p  = o0_pak;
                ok = 1'b1;
                repeat (50) begin
                    @(negedge clk);
                    if (o0_req !== 1'b1 || o0_pak !== p) ok = 1'b0;
                end
                check("stall_stable", ok, 1'b1);
            end
            recv_pkt(exp1[k], "m1_pkt");
        end
        settle();
        check("m1_sent_cnt", sent_cnt, 8'd1);
        check("m1_no_more_req", o0_req, 1'b0);

        // Fill the FIFO with the consumer stalled; the fifth request must be held off.
        for (int i = 0; i < 5; i++) mq[i] = gen(i + 40);
        for (int i = 0; i < 4; i++) push(mq[i]);
        @(negedge clk);
        {i0_src, i0_dst, i0_dat, i0_red} = mq[4];
        i0_req = 1'b1;
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (i0_ack !== 1'b0) ok = 1'b0;
        end
        check("full_holdoff", ok, 1'b1);
        recv_msg(mq[0]);
        n = 0;
        while (i0_ack !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("full_late_ack", i0_ack, 1'b1);
        i0_req = 1'b0;
        n = 0;
        while (i0_ack !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("full_late_ack_clr", i0_ack, 1'b0);
        for (int i = 1; i < 5; i++) recv_msg(mq[i]);
        settle();
        check("full_sent_cnt", sent_cnt, 8'd6);

        // Corrupted redundancy field.
        mbad = {6'd7, 6'd2, 32'hA5A5_A5A5, ~redun(6'd7, 6'd2, 32'hA5A5_A5A5)};
        push(mbad);
`ifdef PAKOUT_TX_REDUN_CHECK_EN
        repeat (20) @(negedge clk);
        check("bad_red_no_pkt", o0_req, 1'b0);
        check("bad_red_err", err_red, 1'b1);
        check("bad_red_cnt", sent_cnt, 8'd6);
`else
        recv_msg(mbad);
        settle();
        check("bad_red_err", err_red, 1'b0);
        check("bad_red_cnt", sent_cnt, 8'd7);
`endif

        // Asynchronous reset during packet 4 with a second message queued.
        ma = gen(100);
        mb = gen(101);
        push(ma);
        push(mb);
        for (int k = 0; k < 4; k++) recv_pkt(pkt(ma, k), "pre_rst_pkt");
        wait_req(1'b1, "req_rise_timeout");
        #2;
        rst = 1'b1;
        #1;
        check("arst_o0_req", o0_req, 1'b0);
        check("arst_sent_cnt", sent_cnt, 8'd0);
        check("arst_o0_pak", o0_pak, 8'h00);
        check("arst_err_red", err_red, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (o0_req !== 1'b0) ok = 1'b0;
        end
        check("arst_fifo_empty", ok, 1'b1);
        mc = gen(102);
        push(mc);
        recv_msg(mc);
        settle();
        check("arst_next_cnt", sent_cnt, 8'd1);

        // 256 messages back to back from reset: counter wrap and ordering.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fork
            begin
                for (int i = 0; i < 256; i++) push(gen(i));
            end
            begin
                for (int j = 0; j < 256; j++) begin
                    recv_msg(gen(j));
                    if (j == 254) begin
                        settle();
                        check("cnt_255", sent_cnt, 8'd255);
                    end
                end
            end
        join
        settle();
        check("cnt_wrap", sent_cnt, 8'd0);
        check("end_idle", o0_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
